// File: rtl/bus_ram_pkg.sv
// Shared types and helpers for the bus RAM slave: FSM states, error codes,
// wait-state LFSR taps and the bus-lane to storage-byte mapping.
package bus_ram_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        READY = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        ERR_NONE  = 2'd0,
        ERR_RANGE = 2'd1,
        ERR_RW    = 2'd2,
        ERR_DROP  = 2'd3
    } err_e;

    // Fibonacci taps 16,14,13,11 (bits 15,13,12,10)
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], ^(s & LFSR_TAPS)};
    endfunction

    function automatic logic [1:0] lane_to_byte(input logic [1:0] k, input logic swap);
        return swap ? (2'd3 - k) : k;
    endfunction

endpackage

// File: rtl/bus_ram_slave_if.sv
// CPU-side memory bus: request/write signals from the master, wait, read data
// and sticky error status back from the slave.
interface bus_ram_slave_if;
    logic [31:0] address;
    logic        read;
    logic        write;
    logic [3:0]  byteenable;
    logic [31:0] writedata;
    logic        waitrequest;
    logic [31:0] readdata;
    logic        err;
    logic [1:0]  err_code;

    modport master (
        output address, read, write, byteenable, writedata,
        input  waitrequest, readdata, err, err_code
    );

    modport slave (
        input  address, read, write, byteenable, writedata,
        output waitrequest, readdata, err, err_code
    );
endinterface

// File: rtl/bus_wait_gen.sv
// Wait-state generator: picks N per request (fixed or LFSR-driven), counts it
// down while the master holds the request, and flags a request dropped mid-wait.
module bus_wait_gen
    import bus_ram_pkg::*;
#(
    parameter int          WAIT_MODE   = 0,
    parameter int          WAIT_CYCLES = 0,
    parameter int          MAX_WAIT    = 3,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic clk,
    input  logic reset,
    input  logic i_req,
    output logic o_ready,
    output logic o_drop_err
);

    state_e      r_state;
    logic [7:0]  r_cnt;
    logic [15:0] r_lfsr;
    logic [7:0]  w_rand;
    logic [7:0]  w_n;

    assign w_rand = 8'(32'(r_lfsr[7:0]) % (MAX_WAIT + 1));
    assign w_n    = (WAIT_MODE == 1) ? w_rand : 8'(WAIT_CYCLES);

    // N=0 is accepted straight from IDLE; otherwise acceptance waits for READY
    assign o_ready    = (r_state == READY) || ((r_state == IDLE) && (w_n == 8'd0));
    assign o_drop_err = (r_state != IDLE) && !i_req;

    // r_cnt holds the wait cycles still owed after the current one, so a
    // request seen at T is accepted at exactly T+N
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= 8'd0;
            r_lfsr  <= LFSR_SEED;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_req) begin
                        r_lfsr <= lfsr_next(r_lfsr);
                        if (w_n == 8'd1) begin
                            r_state <= READY;
                        end else if (w_n > 8'd1) begin
                            r_state <= WAIT;
                            r_cnt   <= w_n - 8'd1;
                        end
                    end
                end
                WAIT: begin
                    if (!i_req) begin
                        r_state <= IDLE;
                        r_cnt   <= 8'd0;
                    end else if (r_cnt == 8'd1) begin
                        r_state <= READY;
                        r_cnt   <= 8'd0;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                READY:   r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/bus_ram_slave.sv
// Parametrised word RAM slave for the CPU bus: programmable base, wait states,
// optional big-endian lane storage, and a sticky first-error latch.
module bus_ram_slave
    import bus_ram_pkg::*;
#(
    parameter int          DEPTH       = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'hBFC00000,
    parameter string       INIT_FILE   = "ram.txt",
    parameter int          WAIT_MODE   = 0,
    parameter int          WAIT_CYCLES = 0,
    parameter int          MAX_WAIT    = 3,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1,
    parameter int          BYTE_SWAP   = 1
) (
    input  logic             clk,
    input  logic             reset,
    bus_ram_slave_if.slave   bus
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [31:0] r_mem [DEPTH] = '{default: 32'h0};
    logic [31:0] r_rdata;
    logic        r_err;
    err_e        r_err_code;

    logic        w_req, w_ready, w_drop_err, w_acc, w_rd, w_wr, w_rw;
    logic        w_zero, w_in_range, w_hit, w_range_err;
    logic [31:0] w_offs;
    logic [AW-1:0] w_idx;
    logic        w_unused;

    bus_wait_gen #(
        .WAIT_MODE   (WAIT_MODE),
        .WAIT_CYCLES (WAIT_CYCLES),
        .MAX_WAIT    (MAX_WAIT),
        .LFSR_SEED   (LFSR_SEED)
    ) u_wait (
        .clk        (clk),
        .reset      (reset),
        .i_req      (w_req),
        .o_ready    (w_ready),
        .o_drop_err (w_drop_err)
    );

    // Wrapping subtraction makes addresses below the base land far out of range
    assign w_offs      = bus.address - BASE_ADDR;
    assign w_unused    = &{1'b0, w_offs[1:0]};
    assign w_idx       = w_offs[AW+1:2];
    assign w_zero      = (bus.address[31:2] == 30'd0);
    assign w_in_range  = ({2'b00, w_offs[31:2]} < 32'(DEPTH));
    assign w_hit       = w_in_range && !w_zero;
    assign w_range_err = !w_in_range && !w_zero;

    assign w_req = bus.read | bus.write;
    assign w_acc = w_req & w_ready;
    assign w_rw  = bus.read & bus.write;
    assign w_rd  = w_acc & bus.read & ~bus.write;
    assign w_wr  = w_acc & bus.write & ~bus.read;

    assign bus.waitrequest = w_req & ~w_ready;
    assign bus.readdata    = r_rdata;
    assign bus.err         = r_err;
    assign bus.err_code    = r_err_code;

    // Memory is deliberately left out of reset; the reset cycle only blocks writes
    always_ff @(posedge clk) begin
        if (!reset && w_wr && w_hit) begin
            for (int k = 0; k < 4; k++) begin
                if (bus.byteenable[k])
                    r_mem[w_idx][8*lane_to_byte(2'(k), BYTE_SWAP != 0) +: 8] <= bus.writedata[8*k +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rdata    <= 32'h0;
            r_err      <= 1'b0;
            r_err_code <= ERR_NONE;
        end else begin
            if (w_rd) begin
                for (int k = 0; k < 4; k++) begin
                    if (bus.byteenable[k])
                        r_rdata[8*k +: 8] <= w_hit ?
                            r_mem[w_idx][8*lane_to_byte(2'(k), BYTE_SWAP != 0) +: 8] : 8'h00;
                end
            end
            if (!r_err) begin
                if (w_drop_err) begin
                    r_err      <= 1'b1;
                    r_err_code <= ERR_DROP;
                end else if (w_acc && w_rw) begin
                    r_err      <= 1'b1;
                    r_err_code <= ERR_RW;
                end else if (w_acc && w_range_err) begin
                    r_err      <= 1'b1;
                    r_err_code <= ERR_RANGE;
                end
            end
        end
    end

endmodule

// File: tb/tb_bus_ram_slave.sv
// Bench for bus_ram_slave: three instances (0 waits, 3 waits, random waits)
// share one master; inactive instances are held in reset.
module tb_bus_ram_slave;

    localparam int          DEPTH = 64;
    localparam logic [31:0] BASE  = 32'hBFC00000;
    localparam logic [15:0] SEED  = 16'hACE1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst [3];
    logic [31:0] m_addr, m_wdata;
    logic        m_rd, m_wr;
    logic [3:0]  m_be;

    logic        wq  [3];
    logic [31:0] rdq [3];
    logic        erq [3];
    logic [1:0]  ecq [3];

    int total = 0;
    int bad   = 0;

    logic [31:0] mdl [3][DEPTH];
    logic [31:0] rd_m [3];
    int          e_code [3];
    logic [15:0] lf;

    bus_ram_slave_if bi [3] ();

    for (genvar g = 0; g < 3; g++) begin : g_bus
        assign bi[g].address    = m_addr;
        assign bi[g].read       = m_rd;
        assign bi[g].write      = m_wr;
        assign bi[g].byteenable = m_be;
        assign bi[g].writedata  = m_wdata;
        assign wq[g]  = bi[g].waitrequest;
        assign rdq[g] = bi[g].readdata;
        assign erq[g] = bi[g].err;
        assign ecq[g] = bi[g].err_code;
    end

    bus_ram_slave #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .INIT_FILE(""), .WAIT_MODE(0),
                    .WAIT_CYCLES(0), .MAX_WAIT(3), .LFSR_SEED(SEED), .BYTE_SWAP(1))
        u0 (.clk(clk), .reset(rst[0]), .bus(bi[0]));
    bus_ram_slave #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .INIT_FILE(""), .WAIT_MODE(0),
                    .WAIT_CYCLES(3), .MAX_WAIT(3), .LFSR_SEED(SEED), .BYTE_SWAP(1))
        u3 (.clk(clk), .reset(rst[1]), .bus(bi[1]));
    bus_ram_slave #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .INIT_FILE(""), .WAIT_MODE(1),
                    .WAIT_CYCLES(0), .MAX_WAIT(3), .LFSR_SEED(SEED), .BYTE_SWAP(1))
        ur (.clk(clk), .reset(rst[2]), .bus(bi[2]));

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wd;
        logic [31:0] exp_rdata;
    } vec_t;
    vec_t tbl [8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] be);
        logic [31:0] r = old;
        for (int k = 0; k < 4; k++) if (be[k]) r[8*k +: 8] = nw[8*k +: 8];
        return r;
    endfunction

    // feedback from register stages 16,14,13,11 (1-based), shifted in at the bottom
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        logic fb = s[15] ^ s[13] ^ s[12] ^ s[10];
        return {s[14:0], fb};
    endfunction

    task automatic model_apply(input int d, input logic rd, input logic wr,
                               input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd);
        logic [31:0] off  = a - BASE;
        logic [29:0] wi   = off[31:2];
        logic        zero = (a < 32'd4);
        logic        inr  = (wi < 30'(DEPTH)) && !zero;
        if (rd && wr) begin
            if (e_code[d] == 0) e_code[d] = 2;
        end else begin
            if (!inr && !zero && e_code[d] == 0) e_code[d] = 1;
            if (wr && inr) mdl[d][int'(wi)] = merge(mdl[d][int'(wi)], wd, be);
            if (rd) rd_m[d] = merge(rd_m[d], inr ? mdl[d][int'(wi)] : 32'h0, be);
        end
    endtask

    // Called at a negedge; returns at the negedge after acceptance, request still driven
    task automatic access(input int d, input logic rd, input logic wr, input logic [31:0] a,
                          input logic [3:0] be, input logic [31:0] wd, output int n);
        m_addr = a; m_be = be; m_wdata = wd; m_rd = rd; m_wr = wr;
        #1;
        n = 0;
        while (wq[d] === 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) chk("access timeout", 32'(n), 32'd0);
        @(negedge clk);
    endtask

    task automatic do_op(input int d, input logic rd, input logic wr, input logic [31:0] a,
                         input logic [3:0] be, input logic [31:0] wd, input string nm,
                         output int n);
        int en;
        if (d == 2) begin
            en = int'(lf[7:0] % 8'd4);
            lf = lfsr_step(lf);
        end else begin
            en = (d == 1) ? 3 : 0;
        end
        access(d, rd, wr, a, be, wd, n);
        model_apply(d, rd, wr, a, be, wd);
        chk({nm, " waits"}, 32'(n), 32'(en));
        chk({nm, " rdata"}, rdq[d], rd_m[d]);
        chk({nm, " err"}, 32'(erq[d]), 32'(e_code[d] != 0));
        chk({nm, " code"}, 32'(ecq[d]), 32'(e_code[d]));
    endtask

    task automatic activate(input int d);
        m_rd = 1'b0; m_wr = 1'b0;
        for (int i = 0; i < 3; i++) rst[i] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst[d]    = 1'b0;
        rd_m[d]   = 32'h0;
        e_code[d] = 0;
        if (d == 2) lf = SEED;
    endtask

    initial begin
        int n;
        int seq [200];
        int hist [4];
        int distinct;

        m_addr = '0; m_wdata = '0; m_rd = 1'b0; m_wr = 1'b0; m_be = '0;
        for (int i = 0; i < 3; i++) begin
            rst[i] = 1'b1; rd_m[i] = '0; e_code[i] = 0;
            for (int j = 0; j < DEPTH; j++) mdl[i][j] = '0;
        end
        for (int i = 0; i < 4; i++) hist[i] = 0;
        lf = SEED;

        tbl[0] = '{1'b0, 1'b1, BASE,          4'hF,    32'h11223344, 32'h00000000};
        tbl[1] = '{1'b1, 1'b0, BASE,          4'hF,    32'h0,        32'h11223344};
        tbl[2] = '{1'b0, 1'b1, BASE + 32'd4,  4'hF,    32'h33333333, 32'h11223344};
        tbl[3] = '{1'b0, 1'b1, BASE + 32'd4,  4'b0101, 32'hAABBCCDD, 32'h11223344};
        tbl[4] = '{1'b1, 1'b0, BASE + 32'd4,  4'hF,    32'h0,        32'h33BB33DD};
        tbl[5] = '{1'b1, 1'b0, BASE,          4'b0011, 32'h0,        32'h33BB3344};
        tbl[6] = '{1'b1, 1'b0, 32'h0,         4'hF,    32'h0,        32'h00000000};
        tbl[7] = '{1'b1, 1'b0, BASE + 32'd7,  4'hF,    32'h0,        32'h33BB33DD};

        // zero-wait instance: reset state, table, random traffic, errors
        activate(0);
        #1;
        chk("rst waitrequest", 32'(wq[0]), 32'd0);
        chk("rst readdata", rdq[0], 32'h0);
        chk("rst err", 32'(erq[0]), 32'd0);
        chk("rst err_code", 32'(ecq[0]), 32'd0);
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            do_op(0, tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].be, tbl[i].wd, "tbl", n);
            chk("tbl expected rdata", rdq[0], tbl[i].exp_rdata);
        end
        chk("addr0 leaves err clear", 32'(erq[0]), 32'd0);
        chk("stored word 0 swapped", u0.r_mem[0], 32'h44332211);
        chk("stored word 1 swapped", u0.r_mem[1], 32'hDD33BB33);

        for (int i = 0; i < 150; i++) begin
            logic [31:0] a  = BASE + 32'($urandom_range(0, 7)) * 32'd4;
            logic [3:0]  be = 4'($urandom);
            logic [31:0] wd = $urandom;
            logic        w  = 1'($urandom_range(0, 1));
            do_op(0, !w, w, a, be, wd, "rnd0", n);
        end

        do_op(0, 1'b1, 1'b0, BASE + 32'(4 * DEPTH), 4'hF, 32'h0, "oor rd", n);
        chk("oor rd code", 32'(ecq[0]), 32'd1);
        do_op(0, 1'b0, 1'b1, BASE + 32'(4 * DEPTH), 4'hF, 32'hFFFFFFFF, "oor wr", n);
        do_op(0, 1'b1, 1'b1, BASE, 4'hF, 32'hDEADBEEF, "rw after oor", n);
        chk("code stays range", 32'(ecq[0]), 32'd1);
        do_op(0, 1'b1, 1'b0, BASE, 4'hF, 32'h0, "word0 intact", n);
        do_op(0, 1'b1, 1'b0, 32'h0, 4'hF, 32'h0, "addr0 rd", n);
        chk("addr0 rdata", rdq[0], 32'h0);

        activate(0);
        @(negedge clk);
        do_op(0, 1'b1, 1'b1, BASE + 32'd4, 4'hF, 32'h12345678, "rw fresh", n);
        chk("rw code", 32'(ecq[0]), 32'd2);
        do_op(0, 1'b1, 1'b0, BASE + 32'd4, 4'hF, 32'h0, "rw no change", n);

        // fixed three-wait instance
        activate(1);
        @(negedge clk);
        do_op(1, 1'b0, 1'b1, BASE, 4'hF, 32'h11223344, "w3 wr", n);
        do_op(1, 1'b1, 1'b0, BASE, 4'hF, 32'h0, "w3 rd", n);
        chk("w3 rd data", rdq[1], 32'h11223344);

        m_rd = 1'b0; m_wr = 1'b0;
        @(negedge clk);
        m_addr = BASE; m_be = 4'hF; m_rd = 1'b1;
        @(negedge clk);
        #1;
        chk("drop still waiting", 32'(wq[1]), 32'd1);
        m_rd = 1'b0;
        @(negedge clk);
        #1;
        chk("drop err", 32'(erq[1]), 32'd1);
        chk("drop code", 32'(ecq[1]), 32'd3);

        activate(1);
        @(negedge clk);
        do_op(1, 1'b1, 1'b0, BASE, 4'hF, 32'h0, "w3 pre", n);
        m_addr = BASE + 32'd8; m_be = 4'hF; m_wdata = 32'hCAFEF00D; m_rd = 1'b0; m_wr = 1'b1;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("wait low 4th cycle", 32'(wq[1]), 32'd0);
        rst[1] = 1'b1;
        @(negedge clk);
        rst[1] = 1'b0; m_wr = 1'b0;
        #1;
        chk("rstmid waitrequest", 32'(wq[1]), 32'd0);
        chk("rstmid readdata", rdq[1], 32'h0);
        chk("rstmid err", 32'(erq[1]), 32'd0);
        chk("rstmid word kept", u3.r_mem[2], 32'h0);
        rd_m[1] = 32'h0; e_code[1] = 0;
        @(negedge clk);
        do_op(1, 1'b1, 1'b0, BASE + 32'd8, 4'hF, 32'h0, "rstmid rd", n);

        // random-wait instance
        activate(2);
        @(negedge clk);
        for (int i = 0; i < 200; i++) begin
            do_op(2, 1'b1, 1'b0, BASE, 4'hF, 32'h0, "rndw", n);
            seq[i] = n;
            chk("rndw bound", 32'(n > 3), 32'd0);
            if (n >= 0 && n <= 3) hist[n]++;
        end
        distinct = 0;
        for (int i = 0; i < 4; i++) if (hist[i] > 0) distinct++;
        chk("rndw all values", 32'(distinct), 32'd4);

        rst[2] = 1'b1;
        @(negedge clk);
        rst[2] = 1'b0;
        lf = SEED; rd_m[2] = 32'h0; e_code[2] = 0;
        for (int i = 0; i < 40; i++) begin
            do_op(2, 1'b1, 1'b0, BASE, 4'hF, 32'h0, "rndw2", n);
            chk("rndw repeat", 32'(n), 32'(seq[i]));
        end
        m_rd = 1'b0;
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
